wb_sdram_arbiter: RTL and testbench
===================================

Name: wb_sdram_arbiter

Overview:
- Round-robin Wishbone B3 arbiter sharing the single SDRAM-controller slave port between N masters (CPU instruction bus, data bus, future DMA).
- Sits between the masters and the SDRAM controller's Wishbone port in the wb_clk domain.
- Holds the grant for a master's whole CYC cycle, so bursts are never split.
- Has a watchdog that aborts with ERR if the slave stalls.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT_CYCLES, 1024, stall limit in cycles; 0 disables the watchdog.

Ports:
- wb_clk  in  1  system clock.
- wb_rst_n  in  1  asynchronous active-low reset.
- m_cyc_i  in  NUM_MASTERS  per-master CYC.
- m_stb_i  in  NUM_MASTERS  per-master STB.
- m_we_i  in  NUM_MASTERS  per-master WE.
- m_adr_i  in  NUM_MASTERS*AW  flattened addresses; master k at [k*AW +: AW].
- m_dat_i  in  NUM_MASTERS*DW  flattened write data.
- m_sel_i  in  NUM_MASTERS*DW/8  flattened byte selects.
- m_cti_i  in  NUM_MASTERS*3  flattened CTI.
- m_bte_i  in  NUM_MASTERS*2  flattened BTE.
- m_dat_o  out  DW  read data, s_dat_i broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ACK.
- m_err_o  out  NUM_MASTERS  per-master ERR.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to the SDRAM controller.
- s_adr_o  out  AW  to the SDRAM controller.
- s_dat_o  out  DW  to the SDRAM controller.
- s_sel_o  out  DW/8  to the SDRAM controller.
- s_cti_o  out  3  to the SDRAM controller.
- s_bte_o  out  2  to the SDRAM controller.
- s_dat_i  in  DW  from the SDRAM controller.
- s_ack_i  in  1  from the SDRAM controller.
- s_err_i  in  1  from the SDRAM controller.
- owner_o  out  clog2(NUM_MASTERS)  current grant index (debug).
- timeout_o  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Reset (wb_rst_n low, asynchronous): state=IDLE; owner=0; last=NUM_MASTERS-1, so master 0 wins first; stall counter=0.
  - All s_* outputs, m_ack_o, m_err_o and timeout_o read 0 immediately.
  - Reset mid-transfer drops s_cyc_o at once, no completion.
- States: IDLE, BUSY, ABORT.
- IDLE:
  - s_cyc_o=s_stb_o=0.
  - If any m_cyc_i is set, pick the first requesting index scanning last+1, last+2, … (mod NUM_MASTERS).
  - Register it as owner and go to BUSY next edge. Arbitration latency is 1 cycle.
- BUSY:
  - s_* = owner's m_* signals, combinationally.
  - m_ack_o[owner]=s_ack_i and m_err_o[owner]=s_err_i; all other bits are 0.
  - Non-owners wait with no response.
  - When m_cyc_i[owner]=0: s_cyc_o goes 0 combinationally that cycle; last<=owner; go to IDLE.
  - There is a minimum one idle cycle between owners.
  - Burst CTI/BTE pass through unchanged. The grant is held while CYC stays high, including across STB gaps.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=s_err_i=0.
  - It clears on ack/err, on stb low, or on leaving BUSY.
  - When the counter reaches TIMEOUT_CYCLES-1 and the stall continues: m_err_o[owner]=1 for that one cycle, timeout_o=1, and the next state is ABORT.
  - Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- ABORT:
  - s_cyc_o=s_stb_o=0; no ack/err to anyone.
  - Wait for m_cyc_i[owner]=0, then last<=owner and go to IDLE.
- Simultaneous events:
  - s_ack_i in the limit cycle: the ack wins, no err, stay BUSY.
  - Owner drops CYC in the limit cycle: the drop wins, no err, go to IDLE.
  - New requests while BUSY or ABORT are ignored until IDLE.
- A master dropping CYC while not owner has no effect.

Decomposition:
- Package wb_sdram_arb_pkg holds:
  - the state enum (IDLE/BUSY/ABORT);
  - CTI constants (CLASSIC=3'b000, INC=3'b010, EOB=3'b111);
  - a function returning the clog2 width.
- Sub-module rr_pick (combinational):
  - inputs: req vector and last index;
  - outputs: the granted index and a valid flag.
  - It is reused by future peripheral arbiters.

Test Plan:
- Reset → single master: m_cyc_i=01, read at 0x0000_0100, slave acks after 3 cycles with 0xDEADBEEF → s_cyc_o rises 1 cycle after the request; m_ack_o=01 and m_dat_o=0xDEADBEEF on the ack cycle; owner_o=0.
- Contention: both masters raise CYC in the same cycle right after reset → master 0 served first. After it drops CYC, one idle cycle, then master 1 is granted. Repeating the request gives order 1 then 0 on the next collision.
- Burst hold: master 0 does an 8-beat INC read (cti 010 ×7, then 111) while master 1 requests at beat 2 → all 8 acks go to master 0 and s_cti_o mirrors it; master 1 is granted only after master 0 drops CYC.
- Watchdog: TIMEOUT_CYCLES=16, slave never acks → exactly 16 stalled cycles, then m_err_o[owner] and timeout_o pulse for 1 cycle and s_cyc_o=0. The master holding CYC 5 more cycles keeps s_cyc_o=0; after it drops CYC, the other master gets the grant.
- Edge collisions: ack in the limit cycle → no err and the transfer completes. Separately, the owner drops CYC in the limit cycle → no err, no timeout_o.
- Async reset mid-burst: wb_rst_n low at beat 3 → s_cyc_o=0 and m_ack_o=0 in the same cycle; after release, master 0 wins first.

Source files
------------

// File: rtl/wb_sdram_arb_pkg.sv
// wb_sdram_arb_pkg: shared state enum, Wishbone CTI codes and width helper for the SDRAM arbiter.
package wb_sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first requester after last (mod N).
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  logic [W-1:0] cand;
  always_comb begin
    idx_o = '0;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = W'((int'(last_i) + i) % N);
      if (req_i[cand]) idx_o = cand;
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: round-robin Wishbone B3 arbiter with per-CYC grant hold and stall watchdog.
module wb_sdram_arbiter
  import wb_sdram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst_n,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [width_of(NUM_MASTERS)-1:0] owner_o,
  output logic                        timeout_o
);
  localparam int OW = width_of(NUM_MASTERS);
  localparam int CW = width_of(TIMEOUT_CYCLES + 1);
  localparam int SW = DW / 8;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_e        state_q;
  logic [OW-1:0] owner_q, last_q, pick;
  logic [CW-1:0] cnt_q;
  logic          pick_v, own_cyc, stall, fire;
  rr_pick #(.N(NUM_MASTERS), .W(OW)) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .idx_o  (pick),
    .valid_o(pick_v)
  );
  assign own_cyc = m_cyc_i[owner_q];
  assign s_cyc_o = (state_q == BUSY) && own_cyc;
  assign s_stb_o = s_cyc_o & m_stb_i[owner_q];
  assign s_we_o = s_cyc_o & m_we_i[owner_q];
  assign s_adr_o = s_cyc_o ? m_adr_i[owner_q*AW +: AW] : '0;
  assign s_dat_o = s_cyc_o ? m_dat_i[owner_q*DW +: DW] : '0;
  assign s_sel_o = s_cyc_o ? m_sel_i[owner_q*SW +: SW] : '0;
  assign s_cti_o = s_cyc_o ? m_cti_i[owner_q*3 +: 3] : '0;
  assign s_bte_o = s_cyc_o ? m_bte_i[owner_q*2 +: 2] : '0;
  assign m_dat_o = s_dat_i;
  // a response or owner drop in the limit cycle pre-empts the abort
  assign stall = s_stb_o & ~s_ack_i & ~s_err_i;
  assign fire = (TIMEOUT_CYCLES > 0) && stall && (cnt_q == LIM);
  assign timeout_o = fire;
  assign owner_o = owner_q;
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_ack_o[owner_q] = s_cyc_o & s_ack_i;
    m_err_o[owner_q] = s_cyc_o & (s_err_i | fire);
  end
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= OW'(NUM_MASTERS - 1);
      cnt_q <= '0;
    end else begin
      cnt_q <= stall ? cnt_q + CW'(cnt_q != '1) : '0;
      if (state_q == IDLE && pick_v) begin
        owner_q <= pick;
        state_q <= BUSY;
      end else if (state_q != IDLE && !own_cyc) begin
        last_q <= owner_q;
        state_q <= IDLE;
      end else if (fire) state_q <= ABORT;
    end
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb_wb_sdram_arbiter: directed scenarios plus random traffic checked against a cycle model.
module tb_wb_sdram_arbiter;
  import wb_sdram_arb_pkg::*;
  localparam int N = 2, AW = 32, DW = 32, T = 16;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] cyc = '0, stb = '0, we = '0;
  logic [N*AW-1:0] adr = '0;
  logic [N*DW-1:0] dat = '0;
  logic [N*DW/8-1:0] sel = '0;
  logic [N*3-1:0] cti = '0;
  logic [N*2-1:0] bte = '0;
  logic [DW-1:0] s_dat_i = '0;
  logic s_ack_i = 0, s_err_i = 0;
  logic [DW-1:0] m_dat_o, s_dat_o;
  logic [N-1:0] m_ack_o, m_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [AW-1:0] s_adr_o;
  logic [DW/8-1:0] s_sel_o;
  logic [2:0] s_cti_o;
  logic [1:0] s_bte_o;
  logic [0:0] owner_o;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb_sdram_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(T)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(adr), .m_dat_i(dat),
    .m_sel_i(sel), .m_cti_i(cti), .m_bte_i(bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .owner_o(owner_o), .timeout_o(timeout_o)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: at most one owner per CYC, a stall run of T cycles aborts, next grant scans after last.
  int md = 0, own = 0, last = N - 1, run = 0;
  int md_n = 0, own_n = 0, last_n = N - 1, run_n = 0;
  always @(negedge clk) begin
    logic ec, es, st, fire, found;
    logic [N-1:0] eack, eerr;
    if (!rst_n) begin
      chk("rst_s_cyc", 64'(s_cyc_o), 0);
      chk("rst_s_stb", 64'(s_stb_o), 0);
      chk("rst_m_ack", 64'(m_ack_o), 0);
      chk("rst_m_err", 64'(m_err_o), 0);
      chk("rst_timeout", 64'(timeout_o), 0);
      chk("rst_owner", 64'(owner_o), 0);
    end else begin
      ec = (md == 1) && cyc[own];
      es = ec && stb[own];
      st = es && !s_ack_i && !s_err_i;
      fire = st && (run == T - 1);
      eack = (ec && s_ack_i) ? N'(1) << own : '0;
      eerr = (ec && (s_err_i || fire)) ? N'(1) << own : '0;
      chk("s_cyc", 64'(s_cyc_o), 64'(ec));
      chk("s_stb", 64'(s_stb_o), 64'(es));
      chk("m_ack", 64'(m_ack_o), 64'(eack));
      chk("m_err", 64'(m_err_o), 64'(eerr));
      chk("timeout", 64'(timeout_o), 64'(fire));
      chk("owner", 64'(owner_o), 64'(own));
      chk("m_dat", 64'(m_dat_o), 64'(s_dat_i));
      if (ec) begin
        chk("s_we", 64'(s_we_o), 64'(we[own]));
        chk("s_adr", 64'(s_adr_o), 64'(adr[own*AW +: AW]));
        chk("s_dat", 64'(s_dat_o), 64'(dat[own*DW +: DW]));
        chk("s_sel", 64'(s_sel_o), 64'(sel[own*(DW/8) +: DW/8]));
        chk("s_cti", 64'(s_cti_o), 64'(cti[own*3 +: 3]));
        chk("s_bte", 64'(s_bte_o), 64'(bte[own*2 +: 2]));
      end
      md_n = md;
      own_n = own;
      last_n = last;
      run_n = st ? run + 1 : 0;
      found = 0;
      if (md == 0) begin
        for (int k = 1; k <= N; k++)
          if (!found && cyc[(last + k) % N]) begin
            found = 1;
            own_n = (last + k) % N;
            md_n = 1;
          end
      end else if (!cyc[own]) begin
        last_n = own;
        md_n = 0;
      end else if (fire) md_n = 2;
    end
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      md <= 0; own <= 0; last <= N - 1; run <= 0;
    end else begin
      md <= md_n; own <= own_n; last <= last_n; run <= run_n;
    end
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic mset(input int k, input logic c, input logic s, input logic w,
                      input logic [31:0] a, input logic [2:0] t);
    cyc[k] = c;
    stb[k] = s;
    we[k] = w;
    adr[k*AW +: AW] = a;
    cti[k*3 +: 3] = t;
  endtask
  task automatic do_reset();
    go();
    rst_n = 0;
    cyc = '0; stb = '0; s_ack_i = 0; s_err_i = 0;
    go();
    go();
    rst_n = 1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "stuck");
  end
  initial begin
    int stalls;
    logic seen;
    mid();
    go(); go();
    rst_n = 1;
    // single master read
    go(); mset(0, 1, 1, 0, 32'h0000_0100, CTI_CLASSIC);
    mid(); chk("arb_latency", 64'(s_cyc_o), 0);
    go(); mid();
    chk("grant_cyc", 64'(s_cyc_o), 1); chk("grant_owner", 64'(owner_o), 0);
    chk("grant_adr", 64'(s_adr_o), 64'h100);
    go();
    go(); s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    mid(); chk("rd_ack", 64'(m_ack_o), 64'b01); chk("rd_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
    go(); s_ack_i = 0; mset(0, 0, 0, 0, 0, CTI_CLASSIC);
    mid(); chk("rd_drop", 64'(s_cyc_o), 0);
    // contention after reset
    do_reset();
    go(); mset(0, 1, 1, 0, 32'h10, CTI_CLASSIC); mset(1, 1, 1, 1, 32'h20, CTI_CLASSIC);
    mid();
    go(); mid(); chk("ct_first", 64'(owner_o), 0);
    go(); s_ack_i = 1;
    mid(); chk("ct_ack0", 64'(m_ack_o), 64'b01);
    go(); s_ack_i = 0; mset(0, 0, 0, 0, 0, CTI_CLASSIC);
    mid(); chk("ct_gap1", 64'(s_cyc_o), 0);
    go(); mset(0, 1, 1, 0, 32'h30, CTI_CLASSIC);
    mid(); chk("ct_gap2", 64'(s_cyc_o), 0);
    go(); mid(); chk("ct_second", 64'(owner_o), 1); chk("ct_second_adr", 64'(s_adr_o), 64'h20);
    go(); mset(1, 0, 0, 0, 0, CTI_CLASSIC);
    go(); go(); mid(); chk("ct_third", 64'(owner_o), 0); chk("ct_third_cyc", 64'(s_cyc_o), 1);
    go(); mset(0, 0, 0, 0, 0, CTI_CLASSIC);
    // burst hold
    do_reset();
    go(); mset(0, 1, 1, 0, 32'h1000, CTI_INC);
    mid();
    for (int b = 0; b < 8; b++) begin
      go();
      s_ack_i = 1;
      cti[2:0] = (b == 7) ? CTI_EOB : CTI_INC;
      adr[AW-1:0] = 32'h1000 + 32'(b * 4);
      if (b == 2) mset(1, 1, 1, 0, 32'h2000, CTI_CLASSIC);
      mid();
      chk("burst_ack", 64'(m_ack_o), 64'b01);
      chk("burst_cti", 64'(s_cti_o), (b == 7) ? 64'h7 : 64'h2);
    end
    go(); s_ack_i = 0; mset(0, 0, 0, 0, 0, CTI_CLASSIC);
    mid(); chk("burst_end", 64'(s_cyc_o), 0);
    go(); mid(); chk("burst_gap", 64'(s_cyc_o), 0);
    go(); mid(); chk("burst_next", 64'(owner_o), 1); chk("burst_next_cyc", 64'(s_cyc_o), 1);
    go(); mset(1, 0, 0, 0, 0, CTI_CLASSIC);
    // watchdog
    do_reset();
    go(); mset(0, 1, 1, 0, 32'h200, CTI_CLASSIC);
    mid();
    stalls = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      go(); mid();
      if (s_cyc_o) stalls++;
      if (timeout_o) begin
        seen = 1;
        chk("wd_err", 64'(m_err_o), 64'b01);
      end
    end
    chk("wd_seen", 64'(seen), 1);
    chk("wd_stalls", 64'(stalls), 16);
    for (int i = 0; i < 5; i++) begin
      go();
      if (i == 0) mset(1, 1, 1, 0, 32'h400, CTI_CLASSIC);
      mid();
      chk("abort_cyc", 64'(s_cyc_o), 0);
      chk("abort_pulse", 64'(timeout_o), 0);
    end
    go(); mset(0, 0, 0, 0, 0, CTI_CLASSIC);
    mid(); chk("abort_drop", 64'(s_cyc_o), 0);
    go(); mid(); chk("abort_gap", 64'(s_cyc_o), 0);
    go(); mid(); chk("abort_next", 64'(owner_o), 1); chk("abort_next_cyc", 64'(s_cyc_o), 1);
    go(); mset(1, 0, 0, 0, 0, CTI_CLASSIC);
    // ack in the limit cycle
    go(); mset(0, 1, 1, 0, 32'h500, CTI_CLASSIC);
    mid();
    for (int i = 0; i < 15; i++) begin go(); mid(); end
    go(); s_ack_i = 1;
    mid();
    chk("lim_ack", 64'(m_ack_o), 64'b01);
    chk("lim_ack_err", 64'(m_err_o), 0);
    chk("lim_ack_to", 64'(timeout_o), 0);
    go(); s_ack_i = 0; mset(0, 0, 0, 0, 0, CTI_CLASSIC);
    // owner drop in the limit cycle
    go(); mset(1, 1, 1, 0, 32'h600, CTI_CLASSIC);
    mid();
    for (int i = 0; i < 15; i++) begin go(); mid(); end
    go(); mset(1, 0, 0, 0, 0, CTI_CLASSIC);
    mid();
    chk("lim_drop_to", 64'(timeout_o), 0);
    chk("lim_drop_err", 64'(m_err_o), 0);
    chk("lim_drop_cyc", 64'(s_cyc_o), 0);
    // async reset mid-burst
    do_reset();
    go(); mset(0, 1, 1, 0, 32'h300, CTI_INC);
    mid();
    for (int b = 0; b < 3; b++) begin
      go(); s_ack_i = 1;
      mid(); chk("rb_ack", 64'(m_ack_o), 64'b01);
    end
    go();
    #2 rst_n = 0;
    #1;
    chk("rb_cyc", 64'(s_cyc_o), 0);
    chk("rb_ack0", 64'(m_ack_o), 0);
    go(); s_ack_i = 0;
    go();
    rst_n = 1;
    mset(0, 1, 1, 0, 32'h700, CTI_CLASSIC); mset(1, 1, 1, 0, 32'h800, CTI_CLASSIC);
    mid();
    go(); mid(); chk("rb_first", 64'(owner_o), 0); chk("rb_first_cyc", 64'(s_cyc_o), 1);
    go(); cyc = '0; stb = '0;
    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic sm;
      go();
      sm = ((c / 250) % 2) == 1;
      for (int k = 0; k < N; k++) begin
        if (!cyc[k]) cyc[k] = ($urandom_range(99) < 25);
        else if ($urandom_range(99) < (sm ? 3 : 8)) cyc[k] = 0;
        stb[k] = cyc[k] && (sm || $urandom_range(99) < 80);
        we[k] = 1'($urandom);
        adr[k*AW +: AW] = $urandom;
        dat[k*DW +: DW] = $urandom;
        sel[k*(DW/8) +: DW/8] = 4'($urandom);
        cti[k*3 +: 3] = 3'($urandom);
        bte[k*2 +: 2] = 2'($urandom);
      end
      s_ack_i = sm ? ($urandom_range(99) < 3) : ($urandom_range(99) < 50);
      s_err_i = !sm && ($urandom_range(99) < 4);
      s_dat_i = $urandom;
    end
    go(); cyc = '0; stb = '0; s_ack_i = 0; s_err_i = 0;
    go(); go(); mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
